// File: rtl/ofm_writeback16.sv
// OFM writeback stage: buffers requantized vectors and writes them
// to the output buffer in NHWC order through a ready/valid port.
module ofm_writeback16 #(
  parameter int LANES      = 16,
  parameter int ADDR_W     = 16,
  parameter int DIM_W      = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    cfg_base,
  input  logic [ADDR_W-1:0]    cfg_row_stride,
  input  logic [DIM_W-1:0]     cfg_num_cblk,
  input  logic [DIM_W-1:0]     cfg_width,
  input  logic [DIM_W-1:0]     cfg_height,
  input  logic                 in_valid,
  input  logic [LANES*8-1:0]   in_ofm_vec,
  output logic                 in_stall,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [LANES*8-1:0]   wr_data,
  input  logic                 wr_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err_overflow,
  output logic                 err_unexpected
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = LANES * 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [DW-1:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     occ, occ_n;

  logic [ADDR_W-1:0] row_stride;
  logic [DIM_W-1:0]  num_cblk, width, height;
  logic [DIM_W-1:0]  cblk, col, row;
  logic [ADDR_W-1:0] addr, row_base;

  logic fifo_empty, fifo_full;
  logic pop, push_try, push, drop;
  logic last_cblk, last_col, last_row;
  logic tile_end, cfg_zero;

  assign fifo_empty = (occ == '0);
  assign fifo_full  = (occ == CW'(FIFO_DEPTH));

  assign wr_en   = (state == RUN) && !fifo_empty;
  assign wr_addr = addr;
  assign wr_data = mem[rd_ptr];
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  assign pop      = wr_en && wr_ready;
  assign push_try = in_valid && (state == RUN);
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push     = push_try && (!fifo_full || pop);
  assign drop     = push_try && fifo_full && !pop;

  assign last_cblk = (cblk == num_cblk - DIM_W'(1));
  assign last_col  = (col == width - DIM_W'(1));
  assign last_row  = (row == height - DIM_W'(1));
  assign tile_end  = pop && last_cblk && last_col && last_row;

  assign cfg_zero = (cfg_num_cblk == '0) ||
                    (cfg_width == '0) ||
                    (cfg_height == '0);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = cfg_zero ? DONE : RUN;
      RUN:     if (tile_end) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    occ_n = occ;
    unique case (1'b1)
      (state == DONE): occ_n = '0;
      (push && !pop):  occ_n = occ + CW'(1);
      (pop && !push):  occ_n = occ - CW'(1);
      default:         ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      occ <= occ_n;
      if (push) begin
        mem[wr_ptr] <= in_ofm_vec;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      // Leftover entries are discarded on the way back to IDLE.
      if (state == DONE) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      in_stall       <= 1'b0;
      row_stride     <= '0;
      num_cblk       <= '0;
      width          <= '0;
      height         <= '0;
      cblk           <= '0;
      col            <= '0;
      row            <= '0;
      addr           <= '0;
      row_base       <= '0;
      err_overflow   <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      state    <= state_n;
      in_stall <= (state_n != IDLE) &&
                  (occ_n >= CW'(FIFO_DEPTH - 2));

      if (state == IDLE && start) begin
        row_stride     <= cfg_row_stride;
        num_cblk       <= cfg_num_cblk;
        width          <= cfg_width;
        height         <= cfg_height;
        cblk           <= '0;
        col            <= '0;
        row            <= '0;
        addr           <= cfg_base;
        row_base       <= cfg_base;
        err_overflow   <= 1'b0;
        err_unexpected <= 1'b0;
      end

      if (drop) err_overflow <= 1'b1;
      if (in_valid && state != RUN) err_unexpected <= 1'b1;

      if (pop) begin
        unique case (1'b1)
          (!last_cblk): begin
            cblk <= cblk + DIM_W'(1);
            addr <= addr + ADDR_W'(1);
          end
          (last_cblk && !last_col): begin
            cblk <= '0;
            col  <= col + DIM_W'(1);
            addr <= addr + ADDR_W'(1);
          end
          (last_cblk && last_col): begin
            cblk     <= '0;
            col      <= '0;
            row      <= row + DIM_W'(1);
            row_base <= row_base + row_stride;
            addr     <= row_base + row_stride;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ofm_writeback16.sv
// Directed bench for ofm_writeback16: address order, data order,
// stall, overflow, wrap-around, empty tile and mid-tile reset.
module tb_ofm_writeback16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [15:0]  cfg_base;
  logic [15:0]  cfg_row_stride;
  logic [9:0]   cfg_num_cblk;
  logic [9:0]   cfg_width;
  logic [9:0]   cfg_height;
  logic         in_valid;
  logic [127:0] in_ofm_vec;
  logic         in_stall;
  logic         wr_en;
  logic [15:0]  wr_addr;
  logic [127:0] wr_data;
  logic         wr_ready;
  logic         busy;
  logic         done;
  logic         err_overflow;
  logic         err_unexpected;

  ofm_writeback16 dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_base       (cfg_base),
    .cfg_row_stride (cfg_row_stride),
    .cfg_num_cblk   (cfg_num_cblk),
    .cfg_width      (cfg_width),
    .cfg_height     (cfg_height),
    .in_valid       (in_valid),
    .in_ofm_vec     (in_ofm_vec),
    .in_stall       (in_stall),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .busy           (busy),
    .done           (done),
    .err_overflow   (err_overflow),
    .err_unexpected (err_unexpected)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sent;
  logic v;

  logic [15:0]  exp_a [$];
  logic [127:0] exp_d [$];

  logic [15:0] a1 [12] = '{
    16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105,
    16'h0110, 16'h0111, 16'h0112, 16'h0113, 16'h0114, 16'h0115
  };
  logic [15:0] a4 [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

  function automatic logic [127:0] mkvec(input int s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = 8'(s * 16 + k);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input logic vi, input int seed, input logic rdy);
    in_valid   = vi;
    in_ofm_vec = vi ? mkvec(seed) : '0;
    wr_ready   = rdy;
    #1;
    if (wr_en && wr_ready) begin
      checks++;
      assert (exp_a.size() != 0) else begin
        errors++;
        $error("FAIL extra_write: observed addr %0h expected none", wr_addr);
      end
      if (exp_a.size() != 0) begin
        chk("wr_addr", wr_addr, exp_a.pop_front());
        chk("wr_data", wr_data, exp_d.pop_front());
      end
    end
    @(negedge clk);
  endtask

  task automatic do_start(input logic [15:0] b, input logic [15:0] s,
                          input logic [9:0] cb, input logic [9:0] w,
                          input logic [9:0] h);
    cfg_base       = b;
    cfg_row_stride = s;
    cfg_num_cblk   = cb;
    cfg_width      = w;
    cfg_height     = h;
    in_valid       = 1'b0;
    wr_ready       = 1'b0;
    start          = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && exp_a.size() > 0; n++) cyc(1'b0, 0, 1'b1);
  endtask

  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    cfg_base       = '0;
    cfg_row_stride = '0;
    cfg_num_cblk   = '0;
    cfg_width      = '0;
    cfg_height     = '0;
    in_valid       = 1'b0;
    in_ofm_vec     = '0;
    wr_ready       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", in_stall, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    rst = 1'b0;
    @(negedge clk);

    cyc(1'b1, 50, 1'b0);
    chk("idle_unexpected", err_unexpected, 1);
    chk("idle_no_wr", wr_en, 0);

    // Basic tile, back-to-back input, memory always ready
    do_start(16'h0100, 16'h0010, 10'd2, 10'd3, 10'd2);
    chk("start_clr_unexp", err_unexpected, 0);
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 12; i++) begin
      exp_a.push_back(a1[i]);
      exp_d.push_back(mkvec(i));
    end
    for (int i = 0; i < 12; i++) cyc(1'b1, i, 1'b1);
    drain();
    chk("t1_all_written", exp_a.size(), 0);
    chk("t1_done", done, 1);
    cyc(1'b0, 0, 1'b1);
    chk("t1_done_pulse", done, 0);
    chk("t1_idle", busy, 0);
    chk("t1_ovf", err_overflow, 0);
    chk("t1_unexp", err_unexpected, 0);

    // Memory stalls 10 cycles, upstream honours in_stall
    do_start(16'h0100, 16'h0010, 10'd2, 10'd3, 10'd2);
    for (int i = 0; i < 12; i++) begin
      exp_a.push_back(a1[i]);
      exp_d.push_back(mkvec(20 + i));
    end
    sent = 0;
    for (int c = 0; c < 80 && (sent < 12 || exp_a.size() > 0); c++) begin
      if (c == 1) chk("t2_stall_occ1", in_stall, 0);
      if (c == 2) chk("t2_stall_occ2", in_stall, 1);
      v = (sent < 12) && !in_stall;
      cyc(v, 20 + sent, c >= 10);
      if (v) sent++;
    end
    chk("t2_all_sent", sent, 12);
    chk("t2_all_written", exp_a.size(), 0);
    chk("t2_ovf", err_overflow, 0);
    chk("t2_done", done, 1);
    cyc(1'b0, 0, 1'b1);

    // Upstream ignores in_stall: two of six vectors are dropped
    do_start(16'h0100, 16'h0010, 10'd2, 10'd3, 10'd2);
    for (int i = 0; i < 4; i++) begin
      exp_a.push_back(a1[i]);
      exp_d.push_back(mkvec(40 + i));
    end
    for (int i = 0; i < 6; i++) cyc(1'b1, 40 + i, 1'b0);
    chk("t3_ovf", err_overflow, 1);
    chk("t3_hold_en", wr_en, 1);
    chk("t3_hold_addr", wr_addr, 16'h0100);
    chk("t3_hold_data", wr_data, mkvec(40));
    chk("t3_stall", in_stall, 1);
    drain();
    chk("t3_written", exp_a.size(), 0);
    chk("t3_empty", wr_en, 0);
    chk("t3_still_run", busy, 1);
    chk("t3_ovf_sticky", err_overflow, 1);
    rst = 1'b1;
    #1;
    chk("t3_rst_ovf", err_overflow, 0);
    chk("t3_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Address wrap-around at the top of the address space
    do_start(16'hFFFE, 16'h0040, 10'd1, 10'd4, 10'd1);
    for (int i = 0; i < 4; i++) begin
      exp_a.push_back(a4[i]);
      exp_d.push_back(mkvec(60 + i));
    end
    for (int i = 0; i < 4; i++) cyc(1'b1, 60 + i, 1'b1);
    drain();
    chk("t4_written", exp_a.size(), 0);
    chk("t4_done", done, 1);
    cyc(1'b0, 0, 1'b1);

    // Zero-width tile completes immediately
    do_start(16'h0200, 16'h0010, 10'd2, 10'd0, 10'd2);
    chk("t5_done", done, 1);
    chk("t5_busy", busy, 1);
    chk("t5_no_wr", wr_en, 0);
    cyc(1'b0, 0, 1'b1);
    chk("t5_done_clr", done, 0);
    chk("t5_idle", busy, 0);
    chk("t5_no_wr2", wr_en, 0);

    // Reset after five writes, then a clean restart
    do_start(16'h0100, 16'h0010, 10'd2, 10'd3, 10'd2);
    for (int i = 0; i < 12; i++) begin
      exp_a.push_back(a1[i]);
      exp_d.push_back(mkvec(80 + i));
    end
    for (int i = 0; i < 12 && exp_a.size() > 7; i++) cyc(1'b1, 80 + i, 1'b1);
    chk("t6_five_written", exp_a.size(), 7);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("t6_rst_wr_en", wr_en, 0);
    chk("t6_rst_addr", wr_addr, 0);
    chk("t6_rst_data", wr_data, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_stall", in_stall, 0);
    chk("t6_rst_ovf", err_overflow, 0);
    chk("t6_rst_unexp", err_unexpected, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_a.delete();
    exp_d.delete();
    @(negedge clk);
    chk("t6_no_wr_after_rst", wr_en, 0);
    do_start(16'h0100, 16'h0010, 10'd2, 10'd3, 10'd2);
    for (int i = 0; i < 12; i++) begin
      exp_a.push_back(a1[i]);
      exp_d.push_back(mkvec(90 + i));
    end
    for (int i = 0; i < 12; i++) cyc(1'b1, 90 + i, 1'b1);
    drain();
    chk("t6_written", exp_a.size(), 0);
    chk("t6_done", done, 1);
    cyc(1'b0, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ofm_writeback16.md
Name: ofm_writeback16

Overview:
- Stage directly downstream of the 16-lane requantize core.
- Accepts one 16×int8 OFM vector per `in_valid` pulse and buffers it in a small FIFO, because the core has no backpressure.
- Generates NHWC output-buffer addresses (channel-block innermost, then column, then row, with a programmable row stride) and writes each vector through a ready/valid memory write port.
- Raises a stall request to the upstream issue logic before the FIFO can overflow, and pulses `done` when the configured tile is fully written.

Parameters:
- LANES, 16, int8 lanes per vector; `wr_data` width is LANES*8.
- ADDR_W, 16, output-buffer word address width.
- DIM_W, 10, width of the width/height/channel-block count fields.
- FIFO_DEPTH, 4, entries in the input FIFO; power of two, ≥ 4.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; latches cfg_* and begins a tile
- cfg_base  in  ADDR_W  address of the first word of the tile
- cfg_row_stride  in  ADDR_W  word distance between starts of consecutive rows
- cfg_num_cblk  in  DIM_W  16-channel blocks per pixel
- cfg_width  in  DIM_W  pixels per row
- cfg_height  in  DIM_W  rows per tile
- in_valid  in  1  OFM vector present (core out_valid)
- in_ofm_vec  in  LANES*8  16 × int8 (core ofm_vec)
- in_stall  out  1  request to upstream to stop issuing vectors
- wr_en  out  1  write request
- wr_addr  out  ADDR_W  write address
- wr_data  out  LANES*8  write data
- wr_ready  in  1  memory accepts the write this cycle
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse on tile completion
- err_overflow  out  1  sticky: a vector was dropped because the FIFO was full
- err_unexpected  out  1  sticky: `in_valid` arrived while IDLE

Behaviour:
- Reset: every output is 0; FSM = IDLE; FIFO empty; all counters, address registers and error flags are 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN: on `start`. Latch cfg_*; set `addr = row_base = cfg_base`; clear `cblk`, `col`, `row`; clear both error flags.
  - IDLE → DONE: on `start` when any of `num_cblk`, `width`, `height` is 0. No writes are issued.
  - RUN → DONE: on the write transfer where `cblk == num_cblk-1`, `col == width-1` and `row == height-1`.
  - DONE → IDLE: unconditionally on the next cycle. `done` = 1 only in DONE.
  - `start` in RUN or DONE is ignored; configuration is not re-latched.
- FIFO push:
  - When `in_valid` = 1 and state is RUN, the vector is pushed.
  - Push when full with no pop in the same cycle: the vector is dropped and `err_overflow` is set.
  - Push when full with a pop in the same cycle: accepted, occupancy is unchanged.
  - `in_valid` while IDLE or DONE: dropped and `err_unexpected` is set.
- FIFO storage is registered. A vector pushed in cycle t can appear on `wr_en` no earlier than cycle t+1.
- Write side:
  - `wr_en = (state == RUN) & fifo_not_empty`.
  - `wr_data` = FIFO head; `wr_addr` = `addr` register.
  - A transfer occurs when `wr_en & wr_ready`; it pops the FIFO and advances the counters.
  - `wr_addr` and `wr_data` hold stable while `wr_en` = 1 and `wr_ready` = 0.
- Counter and address update on a transfer:
  - `cblk < num_cblk-1`: `cblk++`, `addr++`.
  - Otherwise, `col < width-1`: `cblk = 0`, `col++`, `addr++` (pixels are contiguous within a row).
  - Otherwise: `cblk = 0`, `col = 0`, `row++`, `row_base += row_stride`, `addr = row_base + row_stride`.
  - All address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- in_stall:
  - Registered; next value is `(occupancy_next >= FIFO_DEPTH-2)`.
  - This margin covers 1 cycle of core latency plus 1 cycle of issue-to-stall reaction, so a compliant upstream never overflows.
  - Forced to 0 in IDLE.
- Vectors beyond the configured total: after DONE the block is IDLE, so extra vectors count as unexpected.
- FIFO entries left in the FIFO on entering DONE are discarded on the transition to IDLE.
- Reset mid-tile: everything returns immediately to reset values; no further `wr_en`.
- Data is passed bit-exact; there is no arithmetic on lane contents and lane 0 stays at bits [7:0].

Test Plan:
- `cfg_base` = 0x0100, `row_stride` = 0x0010, `num_cblk` = 2, `width` = 3, `height` = 2; 12 back-to-back `in_valid`, `wr_ready` = 1 → addresses 0x100–0x105, then 0x110–0x115, data in push order; `done` pulses exactly 1 cycle after the 12th transfer; `err_*` = 0.
- Same configuration, `wr_ready` low for 10 cycles while `in_valid` continues, with upstream obeying `in_stall` → `in_stall` rises at occupancy 2, no drop; 12 writes complete in order.
- `wr_ready` held at 0, upstream ignores `in_stall`, 6 vectors pushed → FIFO holds the first 4, `err_overflow` = 1; after `wr_ready` = 1 the first 4 vectors are written at the correct addresses.
- `cfg_base` = 0xFFFE, `num_cblk` = 1, `width` = 4, `height` = 1 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- `start` with `cfg_width` = 0 → `done` pulses on the next cycle; `wr_en` never asserts; `busy` is high for 1 cycle.
- `rst` asserted after 5 of 12 writes → all outputs are 0 in the same cycle; a fresh `start` restarts the tile at `cfg_base`.
